// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Data has priority and a starvation counter forces fetch progress. Defining
// MEM_TIMEOUT_EN adds an ack watchdog that aborts stuck accesses.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_err
);

  localparam logic [2:0]  OP_WORD = 3'b010;
  localparam int unsigned SW      = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] wdata_q;

  logic busy, timeout, done, arb;
  logic if_elig, d_elig, grant_if, grant_d;

  assign busy = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = busy && !mem_ack && (to_cnt == TW'(TIMEOUT_CYC));

  // Every arbitration point (idle, ack, abort) is where a grant may occur,
  // so clearing there also covers "clear on grant".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 to_cnt <= '0;
    else if (arb)               to_cnt <= '0;
    else if (busy && !mem_ack)  to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = busy && (mem_ack || timeout);
  assign arb  = !busy || done;

  // The completing requester only re-requests a cycle later, so it is
  // excluded from the decision taken in its own completion cycle.
  assign if_elig  = if_req && !(state == IF_ACC && done);
  assign d_elig   = d_req  && !(state == D_ACC  && done);
  assign grant_if = arb && if_elig && (!d_elig || starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d  = arb && d_elig && !grant_if;

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_err   = timeout;

    if (grant_if)      state_nx = IF_ACC;
    else if (grant_d)  state_nx = D_ACC;
    else if (arb)      state_nx = IDLE;

    if (grant_if || !if_req)
      starve_nx = '0;
    else if (grant_d && starve_cnt != SW'(STARVE_LIMIT))
      starve_nx = starve_cnt + SW'(1);

    if (state == IF_ACC && done) begin
      if_valid = 1'b1;
      if (mem_ack) if_rdata = mem_rdata;
    end
    if (state == D_ACC && done) begin
      d_valid = 1'b1;
      if (mem_ack && !we_q) d_rdata = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (grant_if) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        op_q    <= OP_WORD;
        wdata_q <= '0;
      end else if (grant_d) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        op_q    <= d_op;
        wdata_q <= d_wdata;
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_op    = op_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_imem_dmem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk, reset;
  logic        if_req, if_valid, d_req, d_we, d_valid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [2:0]  d_op, mem_op;
  logic        mem_req, mem_we, mem_ack, stall_if, stall_mem, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // Memory model: acks after cur_wait wait cycles; the wait for the next
  // access is loaded whenever the memory is idle or an access ends.
  int unsigned next_wait, cur_wait, wcnt;
  logic never_ack;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= 0; cur_wait <= 0;
    end else if (!mem_req || mem_ack || mem_err) begin
      wcnt <= 0; cur_wait <= next_wait;
    end else begin
      wcnt <= wcnt + 1;
    end
  end
  assign mem_ack   = mem_req && !never_ack && (wcnt == cur_wait);
  assign mem_rdata = memf(mem_addr);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_op, mem_addr, mem_wdata, if_valid, d_valid,
         if_rdata, d_rdata, mem_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b we=%b op=%h addr=%h wd=%h iv=%b dv=%b ir=%h dr=%h err=%b want all 0",
               mem_req, mem_we, mem_op, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata, mem_err);
    end
    n_cmp++;
    if (stall_mem !== 1'b0) begin n_err++; $display("FAIL reset_stall_mem: got %b want 0", stall_mem); end
  endtask

  task automatic test_first_fetch;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, stall_if} !== 2'b01) begin
      n_err++; $display("FAIL release_state: got req=%b stall_if=%b want 0/1", mem_req, stall_if);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_op, mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h0000_1000}) begin
      n_err++; $display("FAIL first_fetch_mem: got req=%b we=%b op=%b addr=%h want 1/0/010/00001000",
                        mem_req, mem_we, mem_op, mem_addr);
    end
    n_cmp++;
    if ({if_valid, d_valid, stall_if, if_rdata} !== {1'b1, 1'b0, 1'b0, memf(32'h0000_1000)}) begin
      n_err++; $display("FAIL first_fetch_valid: got iv=%b dv=%b stall=%b rd=%h want 1/0/0/%h",
                        if_valid, d_valid, stall_if, if_rdata, memf(32'h0000_1000));
    end
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, if_valid, if_rdata} !== '0) begin
      n_err++; $display("FAIL first_fetch_idle: got req=%b iv=%b rd=%h want 0", mem_req, if_valid, if_rdata);
    end
  endtask

  task automatic test_priority;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h0000_0100;
    next_wait = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, d_valid, if_valid, stall_if, stall_mem} !== {32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL prio_data_first: got addr=%h dv=%b iv=%b sif=%b smem=%b want 00000100/1/0/1/0",
                        mem_addr, d_valid, if_valid, stall_if, stall_mem);
    end
    n_cmp++;
    if (d_rdata !== memf(32'h0000_0100)) begin
      n_err++; $display("FAIL prio_d_rdata: got %h want %h", d_rdata, memf(32'h0000_0100));
    end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_op, if_valid, d_valid, if_rdata} !==
        {32'h0000_2000, 3'b010, 1'b1, 1'b0, memf(32'h0000_2000)}) begin
      n_err++; $display("FAIL prio_fetch_next: got addr=%h op=%b iv=%b dv=%b rd=%h",
                        mem_addr, mem_op, if_valid, d_valid, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL prio_idle: got req=%b want 0", mem_req); end
  endtask

  task automatic test_store_wait;
    d_req = 1'b1; d_we = 1'b1; d_op = 3'b000; d_addr = 32'h0000_0300; d_wdata = 32'hDEAD_BEEF;
    next_wait = 3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, mem_op, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'b000, 32'h0000_0300, 32'hDEAD_BEEF}) begin
        n_err++; $display("FAIL store_hold[%0d]: got req=%b we=%b op=%b addr=%h wd=%h", k,
                          mem_req, mem_we, mem_op, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({d_valid, stall_mem, d_rdata} !== {(k == 4), (k != 4), 32'h0}) begin
        n_err++; $display("FAIL store_valid[%0d]: got dv=%b smem=%b rd=%h want %b/%b/0", k,
                          d_valid, stall_mem, d_rdata, (k == 4), (k != 4));
      end
      // the latched copy, not the live inputs, must drive the memory
      if (k == 1) begin d_addr = 32'hFFFF_FFFC; d_wdata = 32'h0; d_op = 3'b111; end
    end
    d_req = 1'b0; d_we = 1'b0; next_wait = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, d_valid} !== 2'b00) begin
      n_err++; $display("FAIL store_idle: got req=%b dv=%b want 0/0", mem_req, d_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic ev_d;
    if_req = 1'b1; if_addr = 32'h0000_4000;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h0000_8000;
    next_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ev_d = (i % 2 == 0);
      n_cmp++;
      if ({mem_req, d_valid, if_valid} !== {1'b1, ev_d, !ev_d}) begin
        n_err++; $display("FAIL b2b_pattern[%0d]: got req=%b dv=%b iv=%b want 1/%b/%b", i,
                          mem_req, d_valid, if_valid, ev_d, !ev_d);
      end
      n_cmp++;
      if (ev_d ? (d_rdata !== memf(d_addr)) : (if_rdata !== memf(if_addr))) begin
        n_err++; $display("FAIL b2b_rdata[%0d]: got d=%h i=%h want %h", i, d_rdata, if_rdata,
                          ev_d ? memf(d_addr) : memf(if_addr));
      end
      if (ev_d) d_addr = d_addr + 4; else if_addr = if_addr + 4;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got req=%b want 0", mem_req); end
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_we = 1'b0; d_op = 3'b100; d_addr = 32'h0000_0400;
    next_wait = 5;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_addr, d_valid, stall_mem} !== {1'b1, 32'h0000_0400, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL midrst_before: got req=%b addr=%h dv=%b smem=%b", mem_req, mem_addr, d_valid, stall_mem);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, d_valid} !== {1'b0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL midrst_abort: got req=%b addr=%h dv=%b want 0/0/0", mem_req, mem_addr, d_valid);
    end
    d_req = 1'b0; next_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, d_valid} !== 2'b00) begin
      n_err++; $display("FAIL midrst_after: got req=%b dv=%b want 0/0", mem_req, d_valid);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    never_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, if_valid, mem_err, if_rdata} !== {1'b1, (k == 9), (k == 9), 32'h0}) begin
        n_err++; $display("FAIL timeout[%0d]: got req=%b iv=%b err=%b rd=%h want 1/%b/%b/0", k,
                          mem_req, if_valid, mem_err, if_rdata, (k == 9), (k == 9));
      end
      if (k == 8) begin d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h0000_0600; end
    end
    if_req = 1'b0; never_ack = 1'b0; next_wait = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, d_valid, mem_err, d_rdata} !== {32'h0000_0600, 1'b1, 1'b0, memf(32'h0000_0600)}) begin
      n_err++; $display("FAIL timeout_next_grant: got addr=%h dv=%b err=%b rd=%h", mem_addr, d_valid, mem_err, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask
`endif

  // Reference model: one memory transaction at a time, owned by fetch (1) or
  // data (2); ownership changes only when idle or on the completing cycle.
  task automatic test_random;
    int          m_owner, m_waited, m_wait, starve, winner;
    logic [31:0] m_addr, m_wdata;
    logic        m_we, exp_ack, e_ifv, e_dv, ie, de;
    logic [2:0]  m_op;
    logic [31:0] e_ifr, e_dr;

    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_owner = 0; m_waited = 0; m_wait = 0; starve = 0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0; m_op = '0;
    exp_ack = 1'b0; e_ifv = 1'b0; e_dv = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!if_req || e_ifv) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || e_dv) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_addr  = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_op    = 3'($urandom_range(0, 7));
        d_wdata = $urandom;
      end

      winner = 0;
      if (m_owner == 0 || exp_ack) begin
        ie = if_req && (m_owner != 1);
        de = d_req && (m_owner != 2);
        if (ie && (!de || starve == LIMIT)) winner = 1;
        else if (de) winner = 2;
        m_owner = winner;
        m_waited = 0;
        if (winner == 1) begin
          m_addr = if_addr; m_we = 1'b0; m_op = 3'b010; m_wdata = '0;
        end else if (winner == 2) begin
          m_addr = d_addr; m_we = d_we; m_op = d_op; m_wdata = d_wdata;
        end
        m_wait = $urandom_range(0, 3);
        next_wait = m_wait;
      end else begin
        m_waited++;
      end
      if (winner == 1 || !if_req) starve = 0;
      else if (winner == 2 && starve < LIMIT) starve++;

      @(negedge clk);
      exp_ack = (m_owner != 0) && (m_waited == m_wait);
      e_ifv = (m_owner == 1) && exp_ack;
      e_dv  = (m_owner == 2) && exp_ack;
      e_ifr = e_ifv ? memf(m_addr) : 32'h0;
      e_dr  = (e_dv && !m_we) ? memf(m_addr) : 32'h0;

      n_cmp++;
      if (mem_req !== (m_owner != 0)) begin
        n_err++; $display("FAIL rnd_mem_req@%0d: got %b want %b", cyc, mem_req, (m_owner != 0));
      end
      if (m_owner != 0) begin
        n_cmp++;
        if ({mem_addr, mem_we, mem_op, mem_wdata} !== {m_addr, m_we, m_op, m_wdata}) begin
          n_err++; $display("FAIL rnd_mem_fields@%0d: got %h/%b/%b/%h want %h/%b/%b/%h", cyc,
                            mem_addr, mem_we, mem_op, mem_wdata, m_addr, m_we, m_op, m_wdata);
        end
      end
      n_cmp++;
      if ({if_valid, d_valid, mem_err} !== {e_ifv, e_dv, 1'b0}) begin
        n_err++; $display("FAIL rnd_valid@%0d: got iv=%b dv=%b err=%b want %b/%b/0", cyc,
                          if_valid, d_valid, mem_err, e_ifv, e_dv);
      end
      n_cmp++;
      if ({if_rdata, d_rdata} !== {e_ifr, e_dr}) begin
        n_err++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", cyc, if_rdata, d_rdata, e_ifr, e_dr);
      end
      n_cmp++;
      if ({stall_if, stall_mem} !== {if_req && !e_ifv, d_req && !e_dv}) begin
        n_err++; $display("FAIL rnd_stall@%0d: got %b/%b want %b/%b", cyc, stall_if, stall_mem,
                          if_req && !e_ifv, d_req && !e_dv);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
    next_wait = 0; never_ack = 1'b0;

    test_reset;
    test_first_fetch;
    test_priority;
    test_store_wait;
    test_back_to_back;
    test_reset_mid;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    test_random;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
